// File: rtl/ulpi_pkg.sv
// Shared types for the ULPI PHY-side receive generator: FSM states, RX CMD
// byte values and the {last,data} entry stored in the packet buffer.
package ulpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TURN_ON   = 3'd1,
    ST_RXCMD     = 3'd2,
    ST_DATA      = 3'd3,
    ST_RXCMD_END = 3'd4,
    ST_TURN_OFF  = 3'd5,
    ST_GAP       = 3'd6
  } rx_state_e;

  localparam logic [7:0] RXCMD_ACTIVE = 8'h11;
  localparam logic [7:0] RXCMD_IDLE   = 8'h01;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ulpi_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with flush; head is valid
// whenever empty is low.
module ulpi_byte_fifo
  import ulpi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        ulpi_clk60,
  input  logic        microwatt_reset,
  input  logic        flush,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // extra pointer bit distinguishes full from empty when the indexes match
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ulpi_clk60 or posedge microwatt_reset) begin
    if (microwatt_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge ulpi_clk60) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/ulpi_phy_rx_gen.sv
// PHY-side ULPI receive generator: replays buffered packets to the link as
// TURN_ON, RX CMD, data bytes, closing RX CMD and turnaround, with an idle gap.
//   state        | meaning
//   ST_IDLE      | bus released, waiting for a complete packet and an idle link
//   ST_TURN_ON   | dir rises, turnaround cycle (nxt=1, data 00)
//   ST_RXCMD     | RX CMD with RxActive set
//   ST_DATA      | one buffered byte per cycle with nxt=1
//   ST_RXCMD_END | RX CMD with RxActive cleared
//   ST_TURN_OFF  | dir falls, packet retired, first idle gap cycle
//   ST_GAP       | remaining idle gap cycles
module ulpi_phy_rx_gen
  import ulpi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic       ulpi_clk60,
  input  logic       microwatt_reset,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  input  logic       ulpi_stp,
  input  logic [7:0] ulpi_data_i,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  output logic [7:0] ulpi_data_o,
  output logic       busy,
  output logic       pkt_done,
  output logic       len_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  // TURN_OFF already counts as the first idle cycle of the gap
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 2) : 8'd0;

  rx_state_e   state;
  rx_state_e   state_nxt;
  logic [CW-1:0] pkt_count;
  logic [7:0]  gap_cnt;
  logic        drain;
  logic        ready_en;
  logic        len_err_q;
  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        flush;
  logic        inc;
  logic        dec;

  assign wr_entry  = '{last: pkt_last, data: pkt_data};
  assign pkt_ready = ready_en & ~full;
  assign push      = pkt_valid & pkt_ready;
  assign flush     = full & (pkt_count == '0);
  assign pop       = (state == ST_DATA) | drain;
  assign inc       = push & pkt_last;
  assign dec       = (state == ST_TURN_OFF);

  ulpi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .ulpi_clk60      (ulpi_clk60),
    .microwatt_reset (microwatt_reset),
    .flush           (flush),
    .push            (push),
    .wr_entry        (wr_entry),
    .pop             (pop),
    .head            (head),
    .full            (full),
    .empty           (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (pkt_count != '0 && !drain && !ulpi_stp && ulpi_data_i == 8'h00)
                      state_nxt = ST_TURN_ON;
      ST_TURN_ON:   state_nxt = ulpi_stp ? ST_RXCMD_END : ST_RXCMD;
      ST_RXCMD:     state_nxt = ulpi_stp ? ST_RXCMD_END : ST_DATA;
      ST_DATA:      if (ulpi_stp || head.last) state_nxt = ST_RXCMD_END;
      ST_RXCMD_END: state_nxt = ST_TURN_OFF;
      ST_TURN_OFF:  state_nxt = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
      ST_GAP:       if (gap_cnt == 8'd0) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ulpi_clk60 or posedge microwatt_reset) begin
    if (microwatt_reset) begin
      state     <= ST_IDLE;
      pkt_count <= '0;
      gap_cnt   <= 8'd0;
      drain     <= 1'b0;
      ready_en  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (flush) len_err_q <= 1'b1;

      case ({inc, dec})
        2'b10:   pkt_count <= pkt_count + CNT_ONE;
        2'b01:   pkt_count <= pkt_count - CNT_ONE;
        default: pkt_count <= pkt_count;
      endcase

      if (state == ST_TURN_OFF)
        gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;

      // an aborted packet keeps popping until its last byte has left the buffer
      if (flush)
        drain <= 1'b0;
      else if ((state == ST_TURN_ON || state == ST_RXCMD) && ulpi_stp)
        drain <= 1'b1;
      else if (state == ST_DATA && ulpi_stp && !head.last)
        drain <= 1'b1;
      else if (drain && !empty && head.last)
        drain <= 1'b0;
    end
  end

  always_comb begin
    ulpi_dir    = 1'b0;
    ulpi_nxt    = 1'b0;
    ulpi_data_o = 8'h00;
    case (state)
      ST_TURN_ON:   begin ulpi_dir = 1'b1; ulpi_nxt = 1'b1; end
      ST_RXCMD:     begin ulpi_dir = 1'b1; ulpi_data_o = RXCMD_ACTIVE; end
      ST_DATA:      begin ulpi_dir = 1'b1; ulpi_nxt = 1'b1; ulpi_data_o = head.data; end
      ST_RXCMD_END: begin ulpi_dir = 1'b1; ulpi_data_o = RXCMD_IDLE; end
      default:      ;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign pkt_done = (state == ST_TURN_OFF);
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_ulpi_phy_rx_gen.sv
// Scoreboard bench for ulpi_phy_rx_gen: expected bus words are derived from
// each packet's bytes and planned STP position; a monitor compares them.
module tb_ulpi_phy_rx_gen;

  localparam int DEPTH = 16;
  localparam int GAP   = 4;

  typedef logic [7:0] byte_q_t[$];

  logic       ulpi_clk60 = 1'b0;
  logic       microwatt_reset = 1'b0;
  logic [7:0] pkt_data = 8'h00;
  logic       pkt_last = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       pkt_ready;
  logic       ulpi_stp = 1'b0;
  logic [7:0] ulpi_data_i = 8'h00;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_o;
  logic       busy;
  logic       pkt_done;
  logic       len_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int pkts_sent = 0;
  int done_q[$];
  int rise_q[$];
  logic [8:0] sbq[$];
  logic [8:0] mon_e;
  logic prev_dir = 1'b0;
  bit   mon_en = 1'b0;

  ulpi_phy_rx_gen #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .ulpi_clk60      (ulpi_clk60),
    .microwatt_reset (microwatt_reset),
    .pkt_data        (pkt_data),
    .pkt_last        (pkt_last),
    .pkt_valid       (pkt_valid),
    .pkt_ready       (pkt_ready),
    .ulpi_stp        (ulpi_stp),
    .ulpi_data_i     (ulpi_data_i),
    .ulpi_dir        (ulpi_dir),
    .ulpi_nxt        (ulpi_nxt),
    .ulpi_data_o     (ulpi_data_o),
    .busy            (busy),
    .pkt_done        (pkt_done),
    .len_err         (len_err)
  );

  always #5 ulpi_clk60 = ~ulpi_clk60;

  always @(posedge ulpi_clk60) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every dir-high cycle must match the next expected {nxt,data}
  always @(negedge ulpi_clk60) begin
    if (mon_en && !microwatt_reset) begin
      if (ulpi_dir) begin
        if (!prev_dir) rise_q.push_back(cyc);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected actual=%0h required=none", {ulpi_nxt, ulpi_data_o});
        end else begin
          mon_e = sbq.pop_front();
          check("bus_word", 32'({ulpi_nxt, ulpi_data_o}), 32'(mon_e));
        end
      end else begin
        check("idle_bus", 32'({ulpi_nxt, ulpi_data_o}), 32'h0);
      end
      if (pkt_done) begin
        done_cnt++;
        done_q.push_back(cyc);
        check("done_at_dir_fall", 32'(prev_dir), 32'h1);
      end
      prev_dir = ulpi_dir;
    end else begin
      prev_dir = 1'b0;
    end
  end

  // o = cycle (0 = TURN_ON) during which STP is high, -1 for no abort
  task automatic expect_pkt(input byte_q_t b, input int o);
    sbq.push_back({1'b1, 8'h00});
    if (o == 0) begin
      sbq.push_back({1'b0, 8'h01});
      return;
    end
    sbq.push_back({1'b0, 8'h11});
    for (int i = 0; i < b.size(); i++)
      if (o < 0 || i <= o - 2) sbq.push_back({1'b1, b[i]});
    sbq.push_back({1'b0, 8'h01});
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge ulpi_clk60);
    pkt_valid = 1'b1;
    pkt_data  = d;
    pkt_last  = l;
    while (!pkt_ready && n < 200) begin
      @(negedge ulpi_clk60);
      n++;
    end
    check("push_ready", 32'(pkt_ready), 32'h1);
    @(posedge ulpi_clk60);
    #1;
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t b);
    for (int i = 0; i < b.size(); i++) push_byte(b[i], i == b.size() - 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge ulpi_clk60);
      n++;
    end while ((busy || sbq.size() != 0) && n < 2000);
    check(name, 32'(busy || sbq.size() != 0), 32'h0);
  endtask

  task automatic wait_dir(input string name);
    int n = 0;
    do begin
      @(negedge ulpi_clk60);
      n++;
    end while (!ulpi_dir && n < 200);
    check(name, 32'(ulpi_dir), 32'h1);
  endtask

  task automatic stp_at(input int o);
    wait_dir("stp_dir_rise");
    repeat (o) @(negedge ulpi_clk60);
    ulpi_stp = 1'b1;
    @(negedge ulpi_clk60);
    ulpi_stp = 1'b0;
  endtask

  task automatic release_link();
    @(negedge ulpi_clk60);
    ulpi_data_i = 8'h00;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t p;
    byte_q_t q;
    int o;
    int len;
    int d0;

    #2 microwatt_reset = 1'b1;
    #1;
    check("rst_dir", 32'(ulpi_dir), 32'h0);
    check("rst_bus", 32'({ulpi_nxt, ulpi_data_o}), 32'h0);
    check("rst_ready", 32'(pkt_ready), 32'h0);
    check("rst_flags", 32'({busy, pkt_done, len_err}), 32'h0);
    repeat (3) @(negedge ulpi_clk60);
    microwatt_reset = 1'b0;
    @(posedge ulpi_clk60);
    #1;
    check("ready_after_rst", 32'(pkt_ready), 32'h1);
    mon_en = 1'b1;

    // basic packet
    ulpi_data_i = 8'h40;
    p = '{8'hC3, 8'hAB, 8'h12, 8'h34};
    d0 = done_cnt;
    expect_pkt(p, -1);
    send_pkt(p);
    pkts_sent++;
    release_link();
    wait_idle("basic_idle");
    check("basic_done_pulses", 32'(done_cnt - d0), 32'h1);

    // back-to-back packets and the enforced gap
    ulpi_data_i = 8'h40;
    p = '{8'hD2};
    q = '{8'h4B, 8'hCD};
    expect_pkt(p, -1);
    expect_pkt(q, -1);
    send_pkt(p);
    send_pkt(q);
    pkts_sent += 2;
    release_link();
    wait_idle("b2b_idle");
    if (done_q.size() >= 2 && rise_q.size() >= 1)
      check("gap_turn_on", 32'(rise_q[rise_q.size()-1] - done_q[done_q.size()-2]), 32'(GAP + 1));
    else
      check("gap_history", 32'(done_q.size()), 32'h2);

    // link busy holds off the start
    ulpi_data_i = 8'h40;
    p = '{8'h5A, 8'h77};
    expect_pkt(p, -1);
    send_pkt(p);
    pkts_sent++;
    repeat (8) begin
      @(negedge ulpi_clk60);
      check("hold_dir_low", 32'(ulpi_dir), 32'h0);
    end
    ulpi_data_i = 8'h00;
    @(negedge ulpi_clk60);
    check("start_next_cycle", 32'(ulpi_dir), 32'h1);
    wait_idle("hold_idle");

    // STP on the second data byte, then a clean following packet
    ulpi_data_i = 8'h40;
    p = '{8'hE1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    q = '{8'h69, 8'hA5, 8'h5A};
    expect_pkt(p, 3);
    expect_pkt(q, -1);
    send_pkt(p);
    send_pkt(q);
    pkts_sent += 2;
    release_link();
    stp_at(3);
    wait_idle("abort_idle");

    // randomized packets, link hold-off and STP position
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(1, 6);
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      o = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len + 1)) : -1;
      ulpi_data_i = 8'($urandom_range(1, 255));
      expect_pkt(p, o);
      send_pkt(p);
      pkts_sent++;
      repeat ($urandom_range(0, 3)) @(negedge ulpi_clk60);
      release_link();
      if (o >= 0) stp_at(o);
      wait_idle("rand_idle");
    end
    check("done_count", 32'(done_cnt), 32'(pkts_sent));

    // overlong packet: buffer fills with no last flag
    ulpi_data_i = 8'h00;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
    @(negedge ulpi_clk60);
    check("ovf_ready_low", 32'(pkt_ready), 32'h0);
    check("ovf_err_pre", 32'(len_err), 32'h0);
    @(posedge ulpi_clk60);
    #1;
    check("ovf_len_err", 32'(len_err), 32'h1);
    check("ovf_flushed", 32'(pkt_ready), 32'h1);
    push_byte(8'hEE, 1'b0);
    repeat (20) @(negedge ulpi_clk60);
    check("ovf_no_dir", 32'({ulpi_dir, busy}), 32'h0);
    check("ovf_err_sticky", 32'(len_err), 32'h1);

    // reset in the middle of DATA
    @(negedge ulpi_clk60);
    microwatt_reset = 1'b1;
    @(negedge ulpi_clk60);
    microwatt_reset = 1'b0;
    ulpi_data_i = 8'h40;
    p = '{8'h2D, 8'h11, 8'h22, 8'h33, 8'h44};
    expect_pkt(p, -1);
    send_pkt(p);
    release_link();
    wait_dir("rst_pkt_rise");
    repeat (3) @(negedge ulpi_clk60);
    #2 microwatt_reset = 1'b1;
    #1;
    check("midrst_dir", 32'(ulpi_dir), 32'h0);
    check("midrst_bus", 32'({ulpi_nxt, ulpi_data_o}), 32'h0);
    check("midrst_flags", 32'({busy, pkt_done, len_err, pkt_ready}), 32'h0);
    sbq.delete();
    @(negedge ulpi_clk60);
    microwatt_reset = 1'b0;
    @(posedge ulpi_clk60);
    #1;
    check("midrst_ready", 32'(pkt_ready), 32'h1);
    ulpi_data_i = 8'h40;
    p = '{8'h4B, 8'h9C, 8'hF0};
    d0 = done_cnt;
    expect_pkt(p, -1);
    send_pkt(p);
    release_link();
    wait_idle("post_rst_idle");
    check("post_rst_done", 32'(done_cnt - d0), 32'h1);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulpi_phy_rx_gen.md
ULPI_PHY_RX_GEN -- requirements
Module: ulpi_phy_rx_gen

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, byte-entry capacity of the packet buffer (power of two, 4..64).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, number of idle ulpi_clk60 cycles enforced between packets.
REQ-003 SHALL have port ulpi_clk60  input  1  ULPI 60 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port microwatt_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pkt_data  input  8  packet byte to enqueue (PID first).
REQ-006 SHALL have port pkt_last  input  1  marks the final byte of a packet.
REQ-007 SHALL have port pkt_valid  input  1  enqueue request; a byte transfers when pkt_valid and pkt_ready are both high.
REQ-008 SHALL have port pkt_ready  output  1  buffer not full.
REQ-009 SHALL have port ulpi_stp  input  1  STP from link.
REQ-010 SHALL have port ulpi_data_i  input  8  link-driven DATA (link to PHY).
REQ-011 SHALL have port ulpi_dir  output  1  DIR to link; 1 = PHY owns bus.
REQ-012 SHALL have port ulpi_nxt  output  1  NXT to link.
REQ-013 SHALL have port ulpi_data_o  output  8  PHY-driven DATA (PHY to link).
REQ-014 SHALL have port busy  output  1  high from leaving IDLE until returning to IDLE.
REQ-015 SHALL have port pkt_done  output  1  one-cycle pulse on entry to TURN_OFF.
REQ-016 SHALL have port len_err  output  1  sticky: packet exceeded FIFO_DEPTH.

Function
REQ-017 SHALL buffer bytes with their last flag in a FIFO, and count complete packets (stored last flags); simultaneous push and pop SHALL be supported.
REQ-018 SHALL implement states IDLE, TURN_ON, RXCMD, DATA, RXCMD_END, TURN_OFF, GAP.
REQ-019 IDLE -> TURN_ON when packet count > 0, ulpi_stp = 0 and ulpi_data_i = 8'h00 in the same cycle; otherwise remain.
REQ-020 TURN_ON (1 cycle): dir=1, nxt=1, data_o=8'h00.
REQ-021 RXCMD (1 cycle): dir=1, nxt=0, data_o=RXCMD_ACTIVE (8'h11: RxActive, LineState J).
REQ-022 DATA: dir=1, nxt=1, data_o=FIFO head, one byte popped per cycle; exit to RXCMD_END after the byte flagged last.
REQ-023 First data byte SHALL appear exactly 3 cycles after the IDLE decision edge; no gaps inside a packet.
REQ-024 RXCMD_END (1 cycle): dir=1, nxt=0, data_o=RXCMD_IDLE (8'h01).
REQ-025 TURN_OFF (1 cycle): dir=0, nxt=0, data_o=8'h00, packet count decremented.
REQ-026 GAP: outputs idle for GAP_CYCLES cycles, then IDLE.
REQ-027 ulpi_stp high during TURN_ON/RXCMD/DATA SHALL abort: remaining bytes of the current packet are discarded up to and including its last byte, next state RXCMD_END.
REQ-028 ulpi_stp high in RXCMD_END/TURN_OFF/GAP/IDLE SHALL be ignored.
REQ-029 If the FIFO is full and packet count = 0, len_err SHALL set and the FIFO SHALL be flushed in the next cycle; len_err clears only on reset.
REQ-030 Outside DIR-high states data_o SHALL be 8'h00 and nxt 0.

Reset
REQ-031 On microwatt_reset assertion, immediately: ulpi_dir=0, ulpi_nxt=0, ulpi_data_o=8'h00, pkt_ready=0 during reset, busy=0, pkt_done=0, len_err=0, FIFO and packet count empty, state IDLE.
REQ-032 Reset mid-packet SHALL release the bus (dir=0) in the same edge-free instant with no RXCMD_END; pkt_ready=1 on the first edge after deassertion.

Structure
REQ-033 Package ulpi_pkg SHALL hold the state enum, RXCMD_ACTIVE, RXCMD_IDLE and the 9-bit {last,data} FIFO entry type.
REQ-034 Sub-module ulpi_byte_fifo SHALL implement the synchronous FIFO (depth FIFO_DEPTH, width 9, full/empty, flush).

Verification
REQ-035 Load C3,AB,12,34(last), link idle -> dir rises; bus sequence 00(nxt1), 11(nxt0), C3,AB,12,34(nxt1), 01(nxt0), dir falls; pkt_done one pulse.
REQ-036 Two packets D2(last) then 4B,CD(last) back-to-back -> second TURN_ON exactly GAP_CYCLES+1 cycles after first TURN_OFF.
REQ-037 Packet queued while ulpi_data_i=8'h40 -> dir stays 0 until ulpi_data_i returns to 00, then start next cycle.
REQ-038 ulpi_stp pulsed on 2nd data byte of 6-byte packet -> 01 RXCMD next cycle, dir falls, following packet starts cleanly at its PID.
REQ-039 Push 17 bytes without last (FIFO_DEPTH=16) -> pkt_ready low at 16, len_err=1, FIFO flushed, no dir assertion.
REQ-040 Assert microwatt_reset during DATA -> dir/nxt/data_o zero immediately; after release, a fresh packet transmits correctly.
